mms_mpacket_tx_sched: RTL and testbench
=======================================

Name: mms_mpacket_tx_sched

Overview:
- Transmit-side scheduler for MAC Merge verify/respond mPackets.
- Takes the level requests send_v (verify state diagram) and send_r (respond state diagram) and arbitrates them against ongoing MAC frame traffic.
- Sequences one complete mPacket byte stream per grant and returns a one-cycle done pulse so the owning state diagram can clear its request.
- Sits between the verify/respond state diagrams and the byte-wide transmit path.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 preamble bytes before the SMD.
- PAYLOAD_LEN, 60, number of 0x00 payload bytes.
- IPG_LEN, 12, idle byte-times held after each mPacket before releasing the path.
- SMD_V, 8'h07, SMD byte for a verify mPacket.
- SMD_R, 8'h19, SMD byte for a respond mPacket.
- MCRC_VAL, 32'h0000_0000, mCRC constant for the all-zero payload; set at integration. Sent MCRC_VAL[7:0] first.

Ports:
- clk  in  1  byte clock
- reset_n  in  1  asynchronous active-low reset
- send_v  in  1  verify mPacket requested (level)
- send_r  in  1  respond mPacket requested (level)
- tx_busy  in  1  MAC frame currently transmitting or holding the path
- tx_ready  in  1  downstream accepts txd this cycle when tx_en=1
- txd  out  8  transmit byte
- tx_en  out  1  txd valid
- mpkt_active  out  1  path owned by scheduler; MAC must not start a frame
- v_done  out  1  one-cycle pulse, verify mPacket fully sent
- r_done  out  1  one-cycle pulse, respond mPacket fully sent

Behaviour:
- Reset (async assert, sync release): state IDLE, txd=0, tx_en=0, mpkt_active=0, v_done=0, r_done=0, counters=0, latched kind cleared. Asserting reset mid-packet aborts at once with no done pulse.
- States: IDLE, PREAMBLE, SMD, PAYLOAD, MCRC, IPG.
- IDLE: grant occurs in a cycle where (send_r|send_v)=1 and tx_busy=0.
  - send_r wins over send_v; the winner kind is latched.
  - Next cycle: state PREAMBLE, tx_en=1, txd=0x55, mpkt_active=1. Latency from grant to first byte is 1 cycle.
  - If tx_busy=1, wait. There is no pre-emption of a MAC frame.
- Byte advance: a byte is consumed only in a cycle with tx_en=1 and tx_ready=1. Otherwise txd and the counter hold.
- PREAMBLE: PREAMBLE_LEN bytes of 0x55, then SMD.
- SMD: one byte, SMD_R or SMD_V per the latched kind.
- PAYLOAD: PAYLOAD_LEN bytes of 0x00.
- MCRC: 4 bytes, LSB first.
- Transition to IPG: on acceptance of the last mCRC byte.
  - Next cycle: tx_en=0, txd=0, state IPG.
  - r_done or v_done (per latched kind) pulses high for exactly that one cycle.
- IPG: counts IPG_LEN cycles with tx_en=0, unconditionally (tx_ready ignored). mpkt_active stays 1; then IDLE with mpkt_active=0.
  - A pending request is re-arbitrated only in IDLE, so back-to-back mPackets are always separated by IPG_LEN + 1 idle cycles minimum.
- Counter: sized for max(PREAMBLE_LEN, PAYLOAD_LEN, IPG_LEN) and cleared on each state entry. The total mPacket is PREAMBLE_LEN + 1 + PAYLOAD_LEN + 4 = 72 bytes at defaults.
- Request deassert mid-packet: the packet still completes and the done pulse still fires.
- A request held high after done is treated as a new request. The requester must drop it within IPG_LEN cycles.
- tx_busy during an mPacket is ignored. The MAC is required to observe mpkt_active.
- Simultaneous send_v and send_r: respond is sent first. Verify follows after IPG if still requested.

Test Plan:
- Reset, then pulse send_v high with tx_busy=0, tx_ready=1 -> tx_en rises 1 cycle after grant. txd sequence is 7x0x55, 0x07, 60x0x00, then MCRC_VAL bytes LSB first. tx_en low next cycle with v_done=1 for exactly one cycle. mpkt_active falls 12 cycles later.
- send_r and send_v both high from the same cycle -> respond packet (SMD 0x19) and r_done first. After at least 13 idle cycles, verify packet (SMD 0x07) and v_done. No overlap of tx_en between the two packets.
- send_r raised while tx_busy=1 for 20 cycles -> no tx_en and mpkt_active=0 until tx_busy falls. First 0x55 appears the cycle after tx_busy=0 is sampled.
- tx_ready toggled 1,0,0,1 throughout a verify packet -> byte order identical to scenario 1. Each byte held stable while tx_ready=0. Total accepted bytes exactly 72.
- reset_n asserted during PAYLOAD byte 30 -> tx_en=0, mpkt_active=0 immediately (asynchronously) and no done pulse. After release with send_v still high, a full fresh packet starts from preamble.
- send_v dropped during SMD -> packet completes all 72 bytes and v_done still pulses once. Scheduler then stays in IDLE.

Source files
------------

// File: rtl/mms_mpacket_tx_sched.sv
// MAC Merge verify/respond mPacket transmit scheduler.
// Arbitrates send_r/send_v against MAC traffic and streams one mPacket per grant.
module mms_mpacket_tx_sched #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned PAYLOAD_LEN  = 60,
  parameter int unsigned IPG_LEN      = 12,
  parameter logic [7:0]  SMD_V        = 8'h07,
  parameter logic [7:0]  SMD_R        = 8'h19,
  parameter logic [31:0] MCRC_VAL     = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send_v,
  input  logic       send_r,
  input  logic       tx_busy,
  input  logic       tx_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       mpkt_active,
  output logic       v_done,
  output logic       r_done
);

  localparam int unsigned MAX_A =
    (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
  localparam int unsigned MAX_B =
    (MAX_A > IPG_LEN) ? MAX_A : IPG_LEN;
  localparam int unsigned CNT_MAX = (MAX_B > 4) ? MAX_B : 4;
  localparam int unsigned CW = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_LEN - 1);
  localparam logic [CW-1:0] IPG_LAST = CW'(IPG_LEN - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(3);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SMD,
    S_PAY,
    S_CRC,
    S_IPG
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kind_q, kind_d;
  logic [7:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          act_q, act_d;
  logic          v_done_q, v_done_d;
  logic          r_done_q, r_done_d;
  logic          acc;

  assign acc = tx_en_q & tx_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    v_done_d = 1'b0;
    r_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((send_r | send_v) & ~tx_busy) begin
          state_d = S_PRE;
          cnt_d   = '0;
          kind_d  = send_r;
        end
      end
      S_PRE: begin
        if (acc) begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_SMD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_SMD: begin
        if (acc) begin
          state_d = S_PAY;
          cnt_d   = '0;
        end
      end
      S_PAY: begin
        if (acc) begin
          if (cnt_q == PAY_LAST) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_CRC: begin
        if (acc) begin
          if (cnt_q == CRC_LAST) begin
            state_d  = S_IPG;
            cnt_d    = '0;
            v_done_d = ~kind_q;
            r_done_d = kind_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_IPG: begin
        // IPG runs on wall-clock cycles; tx_ready plays no part here
        if (cnt_q == IPG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    act_d   = (state_d != S_IDLE);
    unique case (state_d)
      S_PRE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
      end
      S_SMD: begin
        txd_d   = kind_d ? SMD_R : SMD_V;
        tx_en_d = 1'b1;
      end
      S_PAY: begin
        txd_d   = 8'h00;
        tx_en_d = 1'b1;
      end
      S_CRC: begin
        tx_en_d = 1'b1;
        unique case (cnt_d[1:0])
          2'd0:    txd_d = MCRC_VAL[7:0];
          2'd1:    txd_d = MCRC_VAL[15:8];
          2'd2:    txd_d = MCRC_VAL[23:16];
          default: txd_d = MCRC_VAL[31:24];
        endcase
      end
      default: begin
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      kind_q   <= 1'b0;
      txd_q    <= 8'h00;
      tx_en_q  <= 1'b0;
      act_q    <= 1'b0;
      v_done_q <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      act_q    <= act_d;
      v_done_q <= v_done_d;
      r_done_q <= r_done_d;
    end
  end

  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign mpkt_active = act_q;
  assign v_done      = v_done_q;
  assign r_done      = r_done_q;

endmodule

// File: tb/tb_mms_mpacket_tx_sched.sv
// Directed bench for mms_mpacket_tx_sched.
// Vector table for arbitration/handshake, task-driven full packets.
module tb_mms_mpacket_tx_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       send_v;
  logic       send_r;
  logic       tx_busy;
  logic       tx_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       mpkt_active;
  logic       v_done;
  logic       r_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] MCRC = 32'h0000_0000;
  localparam int PKT_LEN = 72;

  always #5 clk = ~clk;

  mms_mpacket_tx_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .send_v      (send_v),
    .send_r      (send_r),
    .tx_busy     (tx_busy),
    .tx_ready    (tx_ready),
    .txd         (txd),
    .tx_en       (tx_en),
    .mpkt_active (mpkt_active),
    .v_done      (v_done),
    .r_done      (r_done)
  );

  typedef struct {
    bit         v;
    bit         r;
    bit         b;
    bit         rdy;
    bit         en;
    logic [7:0] txd;
    bit         act;
    bit         vd;
    bit         rd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input bit is_r);
    logic [31:0] w;
    w = MCRC >> (8 * ((idx >= 68) ? idx - 68 : 0));
    if (idx < 7)        return 8'h55;
    else if (idx == 7)  return is_r ? 8'h19 : 8'h07;
    else if (idx < 68)  return 8'h00;
    else                return w[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one packet from byte start_idx; rmode 1 = ready 1,0,0,1
  task automatic run_pkt(input bit is_r, input int start_idx,
                         input int rmode, input bit drop_smd,
                         input bit clr_done);
    int idx;
    int cyc;
    int t;
    bit hold;
    logic [7:0] prev;
    idx  = start_idx;
    cyc  = 0;
    t    = 0;
    hold = 1'b0;
    prev = 8'h00;
    while (tx_en !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (tx_en !== 1'b1) begin
      chk("pkt_start_timeout", 0, 1);
      return;
    end
    while (tx_en === 1'b1 && cyc < 1000) begin
      if (hold) chk("byte_hold", txd, prev);
      if (drop_smd && idx == 7) begin
        send_v = 1'b0;
        send_r = 1'b0;
      end
      tx_ready = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (tx_ready) begin
        chk($sformatf("byte%0d", idx), txd, exp_byte(idx, is_r));
        idx++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        prev = txd;
      end
      cyc++;
      step();
    end
    tx_ready = 1'b1;
    chk("byte_count", idx, PKT_LEN);
    chk("done_kind", {v_done, r_done}, {~is_r, is_r});
    chk("ipg_txd", txd, 0);
    if (clr_done) begin
      if (is_r) send_r = 1'b0;
      else      send_v = 1'b0;
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("ipg%0d_quiet", k), {tx_en, v_done, r_done}, 0);
      chk($sformatf("ipg%0d_active", k), mpkt_active, (k < 12) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    tbl[0]  = '{0, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 1, 8'h55, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 8'h55, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 8'h19, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 8'h19, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 8'h00, 1, 0, 0};

    reset_n  = 1'b0;
    send_v   = 1'b0;
    send_r   = 1'b0;
    tx_busy  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
    chk("rst_state", {tx_en, mpkt_active, v_done, r_done}, 0);
    chk("rst_txd", txd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Arbitration, tx_busy block, tx_ready stall, preamble length
    for (int i = 0; i < 14; i++) begin
      send_v   = tbl[i].v;
      send_r   = tbl[i].r;
      tx_busy  = tbl[i].b;
      tx_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_en", i), tx_en, tbl[i].en);
      chk($sformatf("vec%0d_txd", i), txd, tbl[i].txd);
      chk($sformatf("vec%0d_act", i), mpkt_active, tbl[i].act);
      chk($sformatf("vec%0d_done", i), {v_done, r_done},
          {tbl[i].vd, tbl[i].rd});
    end
    tx_busy = 1'b0;
    run_pkt(1'b1, 8, 0, 1'b0, 1'b0);

    // Single verify pulse, 1-cycle grant latency
    send_v = 1'b1;
    step();
    send_v = 1'b0;
    chk("v_latency_en", tx_en, 1);
    chk("v_latency_txd", txd, 8'h55);
    run_pkt(1'b0, 0, 0, 1'b0, 1'b0);

    // Simultaneous requests: respond first, verify after IPG
    send_r = 1'b1;
    send_v = 1'b1;
    step();
    chk("both_first_en", tx_en, 1);
    run_pkt(1'b1, 0, 0, 1'b0, 1'b1);
    step();
    chk("b2b_gap_en", tx_en, 1);
    run_pkt(1'b0, 0, 0, 1'b0, 1'b1);

    // Held off by MAC traffic for 20 cycles
    tx_busy = 1'b1;
    send_r  = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_en !== 1'b0 || mpkt_active !== 1'b0) bad++;
    end
    chk("busy_hold_cycles", bad, 0);
    tx_busy = 1'b0;
    step();
    chk("busy_release_en", tx_en, 1);
    chk("busy_release_txd", txd, 8'h55);
    run_pkt(1'b1, 0, 0, 1'b0, 1'b1);

    // Ready pattern 1,0,0,1 throughout a verify packet
    send_v = 1'b1;
    step();
    send_v = 1'b0;
    run_pkt(1'b0, 0, 1, 1'b0, 1'b0);

    // Reset during payload byte 30
    send_v = 1'b1;
    step();
    for (int k = 0; k < 38; k++) step();
    chk("pre_rst_en", tx_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_en", tx_en, 0);
    chk("async_rst_act", mpkt_active, 0);
    repeat (2) step();
    chk("rst_no_done", {v_done, r_done, tx_en}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rst_restart_txd", txd, 8'h55);
    run_pkt(1'b0, 0, 0, 1'b0, 1'b1);

    // Request dropped during SMD
    send_v = 1'b1;
    step();
    run_pkt(1'b0, 0, 0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_en !== 1'b0 || mpkt_active !== 1'b0 ||
          v_done !== 1'b0 || r_done !== 1'b0) bad++;
    end
    chk("stay_idle_cycles", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
